// File: rtl/cp0_timer.sv
// cp0_timer: CP0 status/cause/EPC registers with a prescaled Count/Compare timer
//   clk, reset (sync, active-low)   clock and reset
//   rd_addr/rd_data                 mfc0 register read (combinational)
//   wr_addr/wr_data/wr_en           mtc0 register write
//   epc_in/exc_code_in/bd_in        M-stage exception information
//   hw_int                          level-sensitive interrupt lines
//   eret                            return from exception, clears EXL
//   req                             take exception/interrupt this cycle
//   epc_out                         current EPC
//   timer_irq                       timer pending bit (Cause.TI)
module cp0_timer #(
  parameter int N_INT = 6,
  parameter int TIMER_LINE = 5,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rd_addr,
  input  logic [4:0]       wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             wr_en,
  input  logic [31:0]      epc_in,
  input  logic [4:0]       exc_code_in,
  input  logic             bd_in,
  input  logic [N_INT-1:0] hw_int,
  input  logic             eret,
  output logic             req,
  output logic [31:0]      epc_out,
  output logic [31:0]      rd_data,
  output logic             timer_irq
);
  logic             r_ie, r_exl, r_bd, r_ti;
  logic [N_INT-1:0] r_im, r_ip;
  logic [4:0]       r_exc;
  logic [31:0]      r_epc, r_count, r_compare;
  logic [7:0]       r_pre;
  logic [N_INT-1:0] w_eff;
  logic             w_int_req, w_exc_req, w_wr, w_tick;
  logic             w_wr_sr, w_wr_epc, w_wr_cnt, w_wr_cmp;
  logic [31:0]      w_count_inc, w_sr, w_cause;
  assign w_eff       = hw_int | (N_INT'(r_ti) << TIMER_LINE);
  assign w_int_req   = |(w_eff & r_im) & r_ie & ~r_exl;
  assign w_exc_req   = ~r_exl & (exc_code_in != 5'd0);
  assign req         = w_int_req | w_exc_req;
  // mtc0 is dropped whenever an exception/interrupt is being taken
  assign w_wr        = wr_en & ~req;
  assign w_wr_sr     = w_wr & (wr_addr == 5'd12);
  assign w_wr_epc    = w_wr & (wr_addr == 5'd14);
  assign w_wr_cnt    = w_wr & (wr_addr == 5'd9);
  assign w_wr_cmp    = w_wr & (wr_addr == 5'd11);
  assign w_tick      = r_pre == 8'(PRESCALE - 1);
  assign w_count_inc = r_count + 32'd1;
  assign w_sr        = (32'(r_im) << 10) | {30'd0, r_exl, r_ie};
  assign w_cause     = {r_bd, r_ti, 30'd0} | (32'(r_ip) << 10) | {25'd0, r_exc, 2'b00};
  assign epc_out     = r_epc;
  assign timer_irq   = r_ti;
  always_comb begin
    rd_data = rd_addr == 5'd12 ? w_sr :
              rd_addr == 5'd13 ? w_cause :
              rd_addr == 5'd14 ? r_epc :
              rd_addr == 5'd9  ? r_count :
              rd_addr == 5'd11 ? r_compare : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ie      <= 1'b0;
      r_exl     <= 1'b0;
      r_im      <= '0;
      r_bd      <= 1'b0;
      r_ti      <= 1'b0;
      r_ip      <= '0;
      r_exc     <= 5'd0;
      r_epc     <= 32'd0;
      r_count   <= 32'd0;
      r_compare <= 32'hFFFF_FFFF;
      r_pre     <= 8'd0;
    end else begin
      r_ip  <= w_eff;
      r_pre <= (w_wr_cnt | w_tick) ? 8'd0 : r_pre + 8'd1;
      r_count <= w_wr_cnt ? wr_data : w_tick ? w_count_inc : r_count;
      if (w_wr_cmp) r_compare <= wr_data;
      // a Compare write clears TI even if the match lands on the same edge
      r_ti <= w_wr_cmp ? 1'b0 : (w_tick & ~w_wr_cnt & (w_count_inc == r_compare)) ? 1'b1 : r_ti;
      if (req) begin
        r_exl <= 1'b1;
        r_bd  <= bd_in;
        r_exc <= w_int_req ? 5'd0 : exc_code_in;
        r_epc <= bd_in ? epc_in - 32'd4 : epc_in;
      end else begin
        if (w_wr_sr) begin
          r_ie  <= wr_data[0];
          r_exl <= wr_data[1];
          r_im  <= wr_data[10 +: N_INT];
        end
        if (eret) r_exl <= 1'b0;
        if (w_wr_epc) r_epc <= wr_data;
      end
    end
  end
endmodule

// File: tb/tb_cp0_timer.sv
// tb_cp0_timer: self-checking bench for cp0_timer (PRESCALE = 4)
module tb_cp0_timer;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr, wr_addr, exc_code_in;
  logic [31:0] wr_data, epc_in, epc_out, rd_data;
  logic        wr_en, bd_in, eret, req, timer_irq;
  logic [5:0]  hw_int;
  int          checks = 0, failures = 0;
  logic [31:0] sb[$];
  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t tbl[6];
  cp0_timer #(.N_INT(6), .TIMER_LINE(5), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en(wr_en), .epc_in(epc_in), .exc_code_in(exc_code_in),
    .bd_in(bd_in), .hw_int(hw_int), .eret(eret), .req(req),
    .epc_out(epc_out), .rd_data(rd_data), .timer_irq(timer_irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    sb.push_back(exp);
    rd_addr = a;
    #1;
    check(nm, rd_data, sb.pop_front());
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask
  initial begin
    tbl[0] = '{5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0000_FC03, "sr_all"};
    tbl[1] = '{5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, "cause_ro"};
    tbl[2] = '{5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678, "epc_wr"};
    tbl[3] = '{5'd11, 32'h0000_1000, 5'd11, 32'h0000_1000, "cmp_wr"};
    tbl[4] = '{5'd20, 32'hFFFF_FFFF, 5'd20, 32'h0000_0000, "addr20"};
    tbl[5] = '{5'd12, 32'h0000_0401, 5'd12, 32'h0000_0401, "sr_401"};
    reset = 1'b0; rd_addr = 5'd0; exc_code_in = 5'd0; epc_in = 32'd0;
    bd_in = 1'b0; eret = 1'b0; hw_int = 6'h3F;
    wr(5'd12, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rd(5'd12, 32'd0, "rst_sr");
    rd(5'd13, 32'd0, "rst_cause");
    rd(5'd14, 32'd0, "rst_epc");
    rd(5'd9, 32'd0, "rst_count");
    rd(5'd11, 32'hFFFF_FFFF, "rst_cmp");
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_tirq", {31'd0, timer_irq}, 32'd0);
    reset = 1'b1; wr_en = 1'b0; hw_int = 6'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr(tbl[i].wa, tbl[i].wd);
      @(negedge clk);
      wr_en = 1'b0;
      rd(tbl[i].ra, tbl[i].exp, tbl[i].nm);
    end
    hw_int = 6'h01; epc_in = 32'h3004; bd_in = 1'b1;
    #1 check("int_req", {31'd0, req}, 32'd1);
    @(negedge clk);
    rd(5'd14, 32'h3000, "int_epc_bd");
    rd(5'd13, 32'h8000_0400, "int_cause");
    rd(5'd12, 32'h0000_0403, "int_sr_exl");
    check("int_req_masked", {31'd0, req}, 32'd0);
    check("int_epc_out", epc_out, 32'h3000);
    hw_int = 6'h00; eret = 1'b1; bd_in = 1'b0;
    @(negedge clk);
    eret = 1'b0;
    rd(5'd12, 32'h0000_0401, "eret_sr");
    hw_int = 6'h01; exc_code_in = 5'd10; epc_in = 32'h5000;
    #1 check("both_req", {31'd0, req}, 32'd1);
    @(negedge clk);
    rd(5'd13, 32'h0000_0400, "int_wins");
    hw_int = 6'h00; exc_code_in = 5'd0; eret = 1'b1;
    wr(5'd12, 32'h0000_0400);
    @(negedge clk);
    eret = 1'b0; wr_en = 1'b0;
    rd(5'd12, 32'h0000_0400, "sr_ie0");
    hw_int = 6'h01; exc_code_in = 5'd10; epc_in = 32'h6000;
    #1 check("exc_req", {31'd0, req}, 32'd1);
    @(negedge clk);
    rd(5'd13, 32'h0000_0428, "exc_cause");
    rd(5'd14, 32'h6000, "exc_epc");
    hw_int = 6'h00; exc_code_in = 5'd0; eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    exc_code_in = 5'd3; epc_in = 32'h7000; eret = 1'b1;
    wr(5'd14, 32'h0000_DEAD);
    #1 check("race_req", {31'd0, req}, 32'd1);
    @(negedge clk);
    exc_code_in = 5'd0; eret = 1'b0; wr_en = 1'b0;
    rd(5'd12, 32'h0000_0402, "race_exl");
    rd(5'd14, 32'h7000, "race_epc");
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    rd(5'd12, 32'h0000_0400, "race_eret");
    wr(5'd11, 32'd2);
    @(negedge clk);
    wr(5'd9, 32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    rd(5'd9, 32'd0, "cnt_load");
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rd(5'd9, 32'(k / 4), $sformatf("cnt_k%0d", k));
      check($sformatf("tirq_k%0d", k), {31'd0, timer_irq}, {31'd0, k == 8});
    end
    rd(5'd13, 32'h4000_000C, "ti_cause");
    wr(5'd12, 32'h0000_8001);
    @(negedge clk);
    wr_en = 1'b0; epc_in = 32'h9000;
    #1 check("timer_req", {31'd0, req}, 32'd1);
    @(negedge clk);
    check("timer_req_exl", {31'd0, req}, 32'd0);
    rd(5'd14, 32'h9000, "timer_epc");
    wr(5'd11, 32'd5);
    @(negedge clk);
    wr_en = 1'b0;
    check("ti_clear", {31'd0, timer_irq}, 32'd0);
    rd(5'd11, 32'd5, "cmp5");
    reset = 1'b0;
    wr(5'd14, 32'h1234);
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b0;
    rd(5'd14, 32'd0, "rst2_epc");
    rd(5'd11, 32'hFFFF_FFFF, "rst2_cmp");
    rd(5'd12, 32'd0, "rst2_sr");
    check("rst2_tirq", {31'd0, timer_irq}, 32'd0);
    check("rst2_req", {31'd0, req}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
